// File: rtl/sc_shift_engine_pkg.sv
// Op codes, FSM state encoding and op-classification helpers shared by the shift engine
// and its single-position step shifter.
package sc_shift_engine_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for the five ops that move bits one position per step.
    function automatic logic opIsShift(input logic [2:0] op);
        logic isShift;
        case (op)
            OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR: isShift = 1'b1;
            default:                                isShift = 1'b0;
        endcase
        return isShift;
    endfunction

    // True when the bit leaving the register is the MSB (left-moving ops).
    function automatic logic opExitsMsb(input logic [2:0] op);
        logic exitsMsb;
        case (op)
            OP_SHL, OP_ROL: exitsMsb = 1'b1;
            default:        exitsMsb = 1'b0;
        endcase
        return exitsMsb;
    endfunction

endpackage

// File: rtl/sc_shift_engine_step.sv
// Combinational single-position shifter/rotator; non-shift ops pass the data through.
module sc_shift_engine_step
    import sc_shift_engine_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] data,
    input  logic [2:0]           op,
    input  logic                 serialBit,
    output logic [DATAWIDTH-1:0] nextData,
    output logic                 outBit
);

    // One-position move selected by op, plus the bit that falls off the end.
    always_comb begin
        nextData = data;
        outBit   = 1'b0;
        case (op)
            OP_SHL: nextData = {data[DATAWIDTH-2:0], serialBit};
            OP_SHR: nextData = {serialBit, data[DATAWIDTH-1:1]};
            OP_SRA: nextData = {data[DATAWIDTH-1], data[DATAWIDTH-1:1]};
            OP_ROL: nextData = {data[DATAWIDTH-2:0], data[DATAWIDTH-1]};
            OP_ROR: nextData = {data[0], data[DATAWIDTH-1:1]};
            default: nextData = data;
        endcase
        if (opIsShift(op)) begin
            outBit = opExitsMsb(op) ? data[DATAWIDTH-1] : data[0];
        end else begin
            outBit = 1'b0;
        end
    end

endmodule

// File: rtl/sc_shift_engine.sv
// Command-driven DATAWIDTH-bit shift register: load/clear/shift/rotate via valid/ready,
// multi-position shifts stepped one position per clock with busy/done status.
module sc_shift_engine
    import sc_shift_engine_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int AMT_W     = $clog2(DATAWIDTH)
) (
    input  logic                 sc_shift_engine_CLOCK_50,
    input  logic                 sc_shift_engine_RESET_InLow,
    input  logic                 sc_shift_engine_clear_InLow,
    input  logic                 sc_shift_engine_cmd_valid_In,
    output logic                 sc_shift_engine_cmd_ready_Out,
    input  logic [2:0]           sc_shift_engine_op_In,
    input  logic [AMT_W-1:0]     sc_shift_engine_amount_In,
    input  logic                 sc_shift_engine_serial_In,
    input  logic [DATAWIDTH-1:0] sc_shift_engine_data_InBUS,
    output logic [DATAWIDTH-1:0] sc_shift_engine_data_OutBUS,
    output logic                 sc_shift_engine_serial_Out,
    output logic                 sc_shift_engine_busy_Out,
    output logic                 sc_shift_engine_done_Out
);

    state_t               state_r;
    state_t               nextState_s;
    logic [DATAWIDTH-1:0] data_r;
    logic [DATAWIDTH-1:0] nextData_s;
    logic                 serialOut_r;
    logic                 nextSerialOut_s;
    logic                 done_r;
    logic                 nextDone_s;
    logic [AMT_W-1:0]     count_r;
    logic [AMT_W-1:0]     nextCount_s;
    logic [2:0]           opHold_r;
    logic [2:0]           nextOpHold_s;
    logic                 serialHold_r;
    logic                 nextSerialHold_s;

    logic                 cmdReady_s;
    logic                 accept_s;
    logic [2:0]           stepOp_s;
    logic                 stepSerial_s;
    logic [DATAWIDTH-1:0] stepData_s;
    logic                 stepOut_s;

    assign cmdReady_s = (state_r == ST_IDLE) && sc_shift_engine_clear_InLow
                        && sc_shift_engine_RESET_InLow;
    assign accept_s   = sc_shift_engine_cmd_valid_In && cmdReady_s;

    // In IDLE the step shifter sees the live command so the first position lands on acceptance.
    always_comb begin
        if (state_r == ST_IDLE) begin
            stepOp_s     = sc_shift_engine_op_In;
            stepSerial_s = sc_shift_engine_serial_In;
        end else begin
            stepOp_s     = opHold_r;
            stepSerial_s = serialHold_r;
        end
    end

    sc_shift_engine_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .data      (data_r),
        .op        (stepOp_s),
        .serialBit (stepSerial_s),
        .nextData  (stepData_s),
        .outBit    (stepOut_s)
    );

    // Next-state, datapath and status decode; the synchronous clear overrides everything last.
    always_comb begin
        nextState_s      = state_r;
        nextData_s       = data_r;
        nextSerialOut_s  = serialOut_r;
        nextDone_s       = 1'b0;
        nextCount_s      = count_r;
        nextOpHold_s     = opHold_r;
        nextSerialHold_s = serialHold_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    nextOpHold_s     = sc_shift_engine_op_In;
                    nextSerialHold_s = sc_shift_engine_serial_In;
                    nextState_s      = ST_DONE;
                    nextDone_s       = 1'b1;
                    case (sc_shift_engine_op_In)
                        OP_LOAD: nextData_s = sc_shift_engine_data_InBUS;
                        OP_CLR: begin
                            nextData_s      = {DATAWIDTH{1'b0}};
                            nextSerialOut_s = 1'b0;
                        end
                        OP_NOP: nextData_s = data_r;
                        default: begin
                            if (sc_shift_engine_amount_In != {AMT_W{1'b0}}) begin
                                nextData_s      = stepData_s;
                                nextSerialOut_s = stepOut_s;
                                nextCount_s     = sc_shift_engine_amount_In - {{(AMT_W-1){1'b0}}, 1'b1};
                                if (sc_shift_engine_amount_In > {{(AMT_W-1){1'b0}}, 1'b1}) begin
                                    nextState_s = ST_SHIFT;
                                    nextDone_s  = 1'b0;
                                end else begin
                                    nextState_s = ST_DONE;
                                end
                            end else begin
                                nextData_s = data_r;
                            end
                        end
                    endcase
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // count_r holds the positions still to go, so count_r==1 is the final step.
                nextData_s      = stepData_s;
                nextSerialOut_s = stepOut_s;
                nextCount_s     = count_r - {{(AMT_W-1){1'b0}}, 1'b1};
                if (count_r <= {{(AMT_W-1){1'b0}}, 1'b1}) begin
                    nextState_s = ST_DONE;
                    nextDone_s  = 1'b1;
                end else begin
                    nextState_s = ST_SHIFT;
                end
            end
            ST_DONE: nextState_s = ST_IDLE;
            default: nextState_s = ST_IDLE;
        endcase

        if (!sc_shift_engine_clear_InLow) begin
            nextState_s     = ST_IDLE;
            nextData_s      = {DATAWIDTH{1'b0}};
            nextSerialOut_s = 1'b0;
            nextCount_s     = {AMT_W{1'b0}};
            nextDone_s      = 1'b0;
        end else begin
            nextDone_s = nextDone_s;
        end
    end

    // State, datapath and status registers with asynchronous active-low reset.
    always_ff @(posedge sc_shift_engine_CLOCK_50 or negedge sc_shift_engine_RESET_InLow) begin
        if (!sc_shift_engine_RESET_InLow) begin
            state_r      <= ST_IDLE;
            data_r       <= {DATAWIDTH{1'b0}};
            serialOut_r  <= 1'b0;
            done_r       <= 1'b0;
            count_r      <= {AMT_W{1'b0}};
            opHold_r     <= OP_NOP;
            serialHold_r <= 1'b0;
        end else begin
            state_r      <= nextState_s;
            data_r       <= nextData_s;
            serialOut_r  <= nextSerialOut_s;
            done_r       <= nextDone_s;
            count_r      <= nextCount_s;
            opHold_r     <= nextOpHold_s;
            serialHold_r <= nextSerialHold_s;
        end
    end

    assign sc_shift_engine_cmd_ready_Out = cmdReady_s;
    assign sc_shift_engine_busy_Out      = (state_r == ST_SHIFT);
    assign sc_shift_engine_data_OutBUS   = data_r;
    assign sc_shift_engine_serial_Out    = serialOut_r;
    assign sc_shift_engine_done_Out      = done_r;

endmodule

// File: tb/tb_sc_shift_engine.sv
// Self-checking bench for sc_shift_engine: directed vector table, hand-written
// hold/clear/reset sequences, and random commands against an arithmetic reference model.
module tb_sc_shift_engine;

    localparam int DW = 8;
    localparam int AW = 3;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] SRA  = 3'd4;
    localparam logic [2:0] ROL  = 3'd5;
    localparam logic [2:0] ROR  = 3'd6;
    localparam logic [2:0] CLR  = 3'd7;

    logic          clk;
    logic          rstN;
    logic          clrN;
    logic          valid;
    logic          ready;
    logic [2:0]    opIn;
    logic [AW-1:0] amtIn;
    logic          serIn;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          serOut;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mReg;
    logic          mSer;

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] amt;
        logic          ser;
        logic [DW-1:0] din;
        logic [DW-1:0] expD;
        logic          expS;
    } vec_t;

    vec_t vecs[$];

    sc_shift_engine #(.DATAWIDTH(DW), .AMT_W(AW)) dut (
        .sc_shift_engine_CLOCK_50      (clk),
        .sc_shift_engine_RESET_InLow   (rstN),
        .sc_shift_engine_clear_InLow   (clrN),
        .sc_shift_engine_cmd_valid_In  (valid),
        .sc_shift_engine_cmd_ready_Out (ready),
        .sc_shift_engine_op_In         (opIn),
        .sc_shift_engine_amount_In     (amtIn),
        .sc_shift_engine_serial_In     (serIn),
        .sc_shift_engine_data_InBUS    (dataIn),
        .sc_shift_engine_data_OutBUS   (dataOut),
        .sc_shift_engine_serial_Out    (serOut),
        .sc_shift_engine_busy_Out      (busy),
        .sc_shift_engine_done_Out      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] amt, input logic ser,
                                input logic [DW-1:0] din, input logic [DW-1:0] expD, input logic expS);
        vec_t v;
        v.op = op; v.amt = amt; v.ser = ser; v.din = din; v.expD = expD; v.expS = expS;
        return v;
    endfunction

    // Whole-command result computed with integer arithmetic: returns {serialOut, register}.
    function automatic logic [DW:0] modelCmd(input logic [2:0] op, input int n, input logic s,
                                             input logic [DW-1:0] din, input logic [DW-1:0] r,
                                             input logic so);
        int v    = int'(r);
        int mask = (1 << DW) - 1;
        int ones = (1 << n) - 1;
        int nv   = v;
        int o    = int'(so);
        if (op == LOAD) begin
            nv = int'(din);
        end else if (op == CLR) begin
            nv = 0; o = 0;
        end else if (op == NOP || n == 0) begin
            nv = v;
        end else if (op == SHL) begin
            nv = ((v << n) | (s ? ones : 0)) & mask;
            o  = (v >> (DW - n)) & 1;
        end else if (op == SHR || op == SRA) begin
            logic fillBit;
            fillBit = (op == SRA) ? r[DW-1] : s;
            nv = ((v >> n) | ((fillBit ? ones : 0) << (DW - n))) & mask;
            o  = (v >> (n - 1)) & 1;
        end else if (op == ROL) begin
            nv = ((v << n) | (v >> (DW - n))) & mask;
            o  = (v >> (DW - n)) & 1;
        end else begin
            nv = ((v >> n) | (v << (DW - n))) & mask;
            o  = (v >> (n - 1)) & 1;
        end
        return {o[0], nv[DW-1:0]};
    endfunction

    task automatic runCmd(input logic [2:0] op, input logic [AW-1:0] amt, input logic ser,
                          input logic [DW-1:0] din, input logic [DW-1:0] expD, input logic expS,
                          input string name);
        int t;
        int cyc;
        int busyCnt;
        int expLat;
        expLat = ((op >= SHL) && (op <= ROR) && (amt != 0)) ? int'(amt) : 1;
        @(negedge clk);
        t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_ready"}, ready, 1);
        opIn = op; amtIn = amt; serIn = ser; dataIn = din; valid = 1'b1;
        @(posedge clk); #1;
        // Scramble command inputs: the engine must have captured them at acceptance.
        valid = 1'b0;
        opIn = 3'($urandom); amtIn = AW'($urandom); serIn = 1'($urandom); dataIn = DW'($urandom);
        cyc = 1;
        busyCnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busyCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_done"}, done, 1);
        check({name, "_latency"}, cyc, expLat);
        check({name, "_busycycles"}, busyCnt, expLat - 1);
        check({name, "_data"}, dataOut, expD);
        check({name, "_serial"}, serOut, expS);
        check({name, "_ready_in_done"}, ready, 0);
        check({name, "_busy_in_done"}, busy, 0);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, done, 0);
        check({name, "_ready_after"}, ready, 1);
    endtask

    task automatic runModel(input logic [2:0] op, input logic [AW-1:0] amt, input logic ser,
                            input logic [DW-1:0] din, input string name);
        logic [DW:0] r;
        r = modelCmd(op, int'(amt), ser, din, mReg, mSer);
        runCmd(op, amt, ser, din, r[DW-1:0], r[DW], name);
        mReg = r[DW-1:0];
        mSer = r[DW];
    endtask

    initial begin
        rstN = 1'b0; clrN = 1'b1; valid = 1'b0;
        opIn = NOP; amtIn = '0; serIn = 1'b0; dataIn = '0;
        mReg = '0; mSer = 1'b0;

        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'hA5, 8'hA5, 1'b0));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h81, 8'h81, 1'b0));
        vecs.push_back(mk(ROL,  3'd3, 1'b0, 8'h00, 8'h0C, 1'b0));
        vecs.push_back(mk(ROR,  3'd3, 1'b0, 8'h00, 8'h81, 1'b1));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h90, 8'h90, 1'b1));
        vecs.push_back(mk(SRA,  3'd2, 1'b0, 8'h00, 8'hE4, 1'b0));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h90, 8'h90, 1'b0));
        vecs.push_back(mk(SHR,  3'd2, 1'b1, 8'h00, 8'hE4, 1'b0));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h80, 8'h80, 1'b0));
        vecs.push_back(mk(SHL,  3'd1, 1'b0, 8'h00, 8'h00, 1'b1));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h3C, 8'h3C, 1'b1));
        vecs.push_back(mk(SHL,  3'd0, 1'b1, 8'h00, 8'h3C, 1'b1));
        vecs.push_back(mk(CLR,  3'd0, 1'b0, 8'hFF, 8'h00, 1'b0));
        vecs.push_back(mk(NOP,  3'd5, 1'b1, 8'hFF, 8'h00, 1'b0));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'hFF, 8'hFF, 1'b0));
        vecs.push_back(mk(SRA,  3'd7, 1'b0, 8'h00, 8'hFF, 1'b1));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h01, 8'h01, 1'b1));
        vecs.push_back(mk(ROR,  3'd1, 1'b0, 8'h00, 8'h80, 1'b1));
        vecs.push_back(mk(LOAD, 3'd0, 1'b0, 8'h5A, 8'h5A, 1'b1));
        vecs.push_back(mk(SHL,  3'd7, 1'b1, 8'h00, 8'h7F, 1'b1));

        // Reset state
        @(posedge clk); #1;
        check("rst_data", dataOut, 0);
        check("rst_serial", serOut, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_after_release", ready, 1);

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            runCmd(vecs[i].op, vecs[i].amt, vecs[i].ser, vecs[i].din,
                   vecs[i].expD, vecs[i].expS, $sformatf("vec%0d", i));
            mReg = vecs[i].expD;
            mSer = vecs[i].expS;
        end

        // cmd_valid held high across DONE: second command waits for IDLE
        @(negedge clk);
        opIn = LOAD; dataIn = 8'h11; valid = 1'b1;
        @(posedge clk); #1;
        check("hold_acc1_data", dataOut, 8'h11);
        check("hold_acc1_done", done, 1);
        check("hold_acc1_ready", ready, 0);
        dataIn = 8'h22;
        @(posedge clk); #1;
        check("hold_not_in_done_data", dataOut, 8'h11);
        check("hold_not_in_done_done", done, 0);
        check("hold_idle_ready", ready, 1);
        @(posedge clk); #1;
        check("hold_acc2_data", dataOut, 8'h22);
        check("hold_acc2_done", done, 1);
        valid = 1'b0;
        @(posedge clk); #1;
        mReg = 8'h22;

        // Clear during a long rotate, with a command presented while clear is low
        runModel(LOAD, 3'd0, 1'b0, 8'h01, "clr_load");
        @(negedge clk);
        opIn = ROL; amtIn = 3'd7; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("clr_busy1", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("clr_busy3", busy, 1);
        @(negedge clk);
        clrN = 1'b0; valid = 1'b1; opIn = LOAD; dataIn = 8'hEE;
        #1;
        check("clr_ready_low", ready, 0);
        @(posedge clk); #1;
        check("clr_data", dataOut, 0);
        check("clr_serial", serOut, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        @(posedge clk); #1;
        check("clr_no_accept_data", dataOut, 0);
        check("clr_no_accept_done", done, 0);
        @(negedge clk);
        valid = 1'b0; clrN = 1'b1;
        #1;
        check("clr_ready_release", ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("clr_no_done%0d", k), done, 0);
        end
        mReg = '0; mSer = 1'b0;

        // Asynchronous reset between edges in the middle of a rotate
        runModel(LOAD, 3'd0, 1'b0, 8'hFF, "arst_load");
        @(negedge clk);
        opIn = ROL; amtIn = 3'd5; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("arst_pre_serial", serOut, 1);
        @(posedge clk); #3;
        rstN = 1'b0;
        #1;
        check("arst_data", dataOut, 0);
        check("arst_serial", serOut, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        check("arst_ready_after", ready, 1);
        check("arst_done_after", done, 0);
        mReg = '0; mSer = 1'b0;
        runModel(LOAD, 3'd0, 1'b0, 8'h3C, "arst_resume_load");
        runModel(ROL, 3'd2, 1'b0, 8'h00, "arst_resume_rol");

        // Random commands against the reference model
        for (int k = 0; k < 60; k++) begin
            runModel(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'($urandom),
                     DW'($urandom), $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
